// File: rtl/item_price_stock.sv
`default_nettype none
// ============================================================================
// Module   : item_price_stock
// Brief    : Per-item writable price table and saturating stock counters.
//            Serves registered lookups, vend/restock events and sold-out flags.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module item_price_stock #(
    parameter int NUM_ITEMS  = 8,
    parameter int SEL_W      = 3,
    parameter int PRICE_W    = 9,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_req,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic                 rd_ack,
    output logic [PRICE_W-1:0]   rd_price,
    output logic [STOCK_W-1:0]   rd_stock,
    output logic                 rd_bad,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_sel,
    input  logic [PRICE_W-1:0]   wr_price,
    input  logic                 rs_en,
    input  logic [SEL_W-1:0]     rs_sel,
    input  logic [STOCK_W-1:0]   rs_qty,
    input  logic                 vend_en,
    input  logic [SEL_W-1:0]     vend_sel,
    output logic                 vend_ok,
    output logic                 vend_err,
    output logic [NUM_ITEMS-1:0] sold_out
);

    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W:0]   SAT_LIMIT = {1'b0, {STOCK_W{1'b1}}};

    // Legacy fixed price list; slots beyond it default to one dollar.
    function automatic logic [PRICE_W-1:0] reset_price(input int idx);
        int cents;
        case (idx)
            0:       cents = 125;
            1:       cents = 100;
            2:       cents = 85;
            3:       cents = 150;
            4:       cents = 225;
            5:       cents = 185;
            6:       cents = 50;
            7:       cents = 135;
            default: cents = 100;
        endcase
        return PRICE_W'(cents);
    endfunction

    logic [NUM_ITEMS-1:0][PRICE_W-1:0] price_tbl;
    logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_tbl;

    logic                 rd_hit;
    logic [PRICE_W-1:0]   rd_price_sel;
    logic [STOCK_W-1:0]   rd_stock_sel;
    logic                 vend_in_range;
    logic                 vend_has_stock;
    logic                 vend_accept;

    // Index decode for lookups and vends; out-of-range selects match no slot.
    always_comb begin
        rd_hit         = 1'b0;
        rd_price_sel   = '0;
        rd_stock_sel   = '0;
        vend_in_range  = 1'b0;
        vend_has_stock = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_hit       = 1'b1;
                rd_price_sel = price_tbl[i];
                rd_stock_sel = stock_tbl[i];
            end
            if (vend_sel == SEL_W'(i)) begin
                vend_in_range  = 1'b1;
                vend_has_stock = (stock_tbl[i] != '0);
            end
        end
    end

    // Acceptance is decided on pre-edge stock only.
    assign vend_accept = vend_en && vend_in_range && vend_has_stock;

    // Registered lookup result and vend outcome pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ack   <= 1'b0;
            rd_price <= '0;
            rd_stock <= '0;
            rd_bad   <= 1'b0;
            vend_ok  <= 1'b0;
            vend_err <= 1'b0;
        end else begin
            rd_ack   <= rd_req;
            vend_ok  <= vend_accept;
            vend_err <= vend_en && !vend_accept;
            if (rd_req) begin
                rd_bad   <= !rd_hit;
                rd_price <= rd_price_sel;
                rd_stock <= rd_stock_sel;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_slot
            logic                 wr_hit;
            logic                 rs_hit;
            logic                 vend_hit;
            logic [STOCK_W-1:0]   rs_add;
            logic [STOCK_W:0]     stock_sum;
            logic [STOCK_W-1:0]   stock_next;
            logic [PRICE_W-1:0]   price_q;
            logic [STOCK_W-1:0]   stock_q;
            logic                 empty_q;

            assign wr_hit   = wr_en && (wr_sel == SEL_W'(i));
            assign rs_hit   = rs_en && (rs_sel == SEL_W'(i));
            assign vend_hit = vend_accept && (vend_sel == SEL_W'(i));
            assign rs_add   = rs_hit ? rs_qty : '0;

            // Extra bit holds the restock carry; a vend only subtracts from non-zero stock.
            always_comb begin
                stock_sum  = {1'b0, stock_q} + {1'b0, rs_add} - {{STOCK_W{1'b0}}, vend_hit};
                stock_next = (stock_sum > SAT_LIMIT) ? {STOCK_W{1'b1}} : stock_sum[STOCK_W-1:0];
            end

            // Slot state: price, stock and sold-out flag from post-update stock.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    price_q <= reset_price(i);
                    stock_q <= STOCK_RST;
                    empty_q <= (INIT_STOCK == 0);
                end else begin
                    if (wr_hit) begin
                        price_q <= wr_price;
                    end
                    stock_q <= stock_next;
                    empty_q <= (stock_next == '0);
                end
            end

            assign price_tbl[i] = price_q;
            assign stock_tbl[i] = stock_q;
            assign sold_out[i]  = empty_q;
        end
    endgenerate

endmodule
`default_nettype wire
